// File: rtl/oppm_pkg.sv
// Shared OPPM definitions: receiver state encoding, link timing defaults
// common to transmitter and receiver, and the maximum-gap helper.
package oppm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_GAP   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } oppm_state_e;

  localparam int N_BITS_DEF   = 4;
  localparam int PULSE_CT_DEF = 10;
  localparam int SLOT_CT_DEF  = 5;
  localparam int GAP_CT_DEF   = 5;
  localparam int TOL_DEF      = 2;

  // Longest accepted low gap: last position plus half a slot of rounding margin.
  function automatic int oppm_dmax(input int n_bits, input int gap_ct, input int slot_ct);
    return gap_ct + ((1 << n_bits) - 1) * slot_ct + slot_ct / 2;
  endfunction

endpackage

// File: rtl/oppm_rx_counter.sv
// Saturating up-counter used for the pulse-width and gap measurements.
// clr_i restarts the count at 1 because the edge that restarts it is itself counted.
module oppm_rx_counter #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = W'(1);
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/oppm_rx.sv
// OPPM symbol receiver: validates sync/data pulse widths and decodes the gap
// into a slot position. Optional input synchronizer: OPPM_RX_SYNC_EN.
module oppm_rx
  import oppm_pkg::*;
#(
  parameter int N_BITS   = N_BITS_DEF,
  parameter int PULSE_CT = PULSE_CT_DEF,
  parameter int SLOT_CT  = SLOT_CT_DEF,
  parameter int GAP_CT   = GAP_CT_DEF,
  parameter int TOL      = TOL_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  output logic [N_BITS-1:0] data,
  output logic              data_valid,
  output logic              err,
  output logic              busy
);

  localparam int DMAX = oppm_dmax(N_BITS, GAP_CT, SLOT_CT);
  localparam int CW   = $clog2(DMAX + 2);
  localparam int PHW  = $clog2(SLOT_CT + 1);
  localparam int THR  = GAP_CT - SLOT_CT / 2;

  localparam logic [CW-1:0] WMIN_C = CW'(PULSE_CT - TOL);
  localparam logic [CW-1:0] WMAX_C = CW'(PULSE_CT + TOL);
  localparam logic [CW-1:0] DMAX_C = CW'(DMAX);
  localparam logic [CW-1:0] THR_C  = (THR > 0) ? CW'(THR) : '0;

  // Slot tracker start values for the first gap edge; non-zero only when the
  // rounding threshold sits at or before that edge.
  localparam int OFF0  = (THR < 1) ? (1 - THR) : 0;
  localparam int POS0I = (OFF0 / SLOT_CT > (1 << N_BITS) - 1) ? (1 << N_BITS) - 1 : OFF0 / SLOT_CT;
  localparam logic [PHW-1:0]    PH0_C    = PHW'(OFF0 % SLOT_CT);
  localparam logic [N_BITS-1:0] POS0_C   = N_BITS'(POS0I);
  localparam logic [PHW-1:0]    PHLAST_C = PHW'(SLOT_CT - 1);

  logic p;

`ifdef OPPM_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pulse_in};
    end
  end
  assign p = sync_q[1];
`else
  assign p = pulse_in;
`endif

  oppm_state_e       state_q, state_d;
  logic [CW-1:0]     wcnt, gcnt;
  logic              w_clr, w_inc, g_clr, g_inc;
  logic [PHW-1:0]    ph_q, ph_d;
  logic [N_BITS-1:0] pos_q, pos_d;
  logic [N_BITS-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  oppm_rx_counter #(.W(CW)) u_width_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (w_clr),
    .en_i  (w_inc),
    .cnt_o (wcnt)
  );

  oppm_rx_counter #(.W(CW)) u_gap_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .clr_i (g_clr),
    .en_i  (g_inc),
    .cnt_o (gcnt)
  );

  always_comb begin
    state_d = state_q;
    w_clr   = 1'b0;
    w_inc   = 1'b0;
    g_clr   = 1'b0;
    g_inc   = 1'b0;
    ph_d    = ph_q;
    pos_d   = pos_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (p) begin
          state_d = ST_SYNC;
          w_clr   = 1'b1;
        end
      end
      ST_SYNC: begin
        if (p) begin
          if (wcnt >= WMAX_C) state_d = ST_DRAIN;
          else                w_inc   = 1'b1;
        end else if (wcnt >= WMIN_C) begin
          state_d = ST_GAP;
          g_clr   = 1'b1;
          ph_d    = PH0_C;
          pos_d   = POS0_C;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (p) begin
          if (gcnt < THR_C) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_DATA;
            w_clr   = 1'b1;
          end
        end else if (gcnt >= DMAX_C) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          g_inc = 1'b1;
          // ph/pos track floor((gap - THR) / SLOT_CT) one edge at a time.
          if (gcnt >= THR_C) begin
            if (ph_q == PHLAST_C) begin
              ph_d = '0;
              if (pos_q != '1) pos_d = pos_q + 1'b1;
            end else begin
              ph_d = ph_q + 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        if (p) begin
          if (wcnt >= WMAX_C) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            w_inc = 1'b1;
          end
        end else if (wcnt >= WMIN_C) begin
          data_d  = pos_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (!p) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      pos_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      pos_q   <= pos_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_oppm_rx.sv
// Directed bench for oppm_rx: stimulus pushes expected strobes (kind, data,
// cycle) into a queue; a negedge monitor pops and compares every strobe.
module tb_oppm_rx;

  localparam int N  = 4;
  localparam int EW = 1 + N + 24;
`ifdef OPPM_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pulse_in = 1'b0;
  logic [N-1:0] data;
  logic         data_valid;
  logic         err;
  logic         busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;

  oppm_rx dut (
    .clk        (clk),
    .rst        (rst),
    .pulse_in   (pulse_in),
    .data       (data),
    .data_valid (data_valid),
    .err        (err),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // driver tasks
  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pulse_in = v;
      @(posedge clk);
      #1;
    end
  endtask

  // Called right after the edge that samples the terminating level.
  task automatic expect_ev(input logic is_err, input int d);
    exp_q.push_back({is_err, N'(d), 24'(cyc + LAT)});
  endtask

  task automatic good_frame(input int gap, input int expd);
    drive(1'b1, 10);
    drive(1'b0, gap);
    drive(1'b1, 10);
    drive(1'b0, 1);
    expect_ev(1'b0, expd);
    drive(1'b0, 4);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (data_valid || err) begin
      check("strobe_exclusive", 32'(data_valid & err), 32'd0);
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("strobe_kind_err", 32'(err), 32'(mon_e[EW-1]));
        if (!mon_e[EW-1]) check("data_value", 32'(data), 32'(mon_e[EW-2 -: N]));
        check("strobe_cycle", 32'(cyc), 32'(mon_e[23:0]));
      end
    end
  end

  initial begin
    rst = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(data), 32'd0);
    check("reset_valid", 32'(data_valid), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 3);

    // position decode, extremes and rounding
    good_frame(20, 3);
    good_frame(5, 0);
    good_frame(80, 15);
    good_frame(22, 3);
    good_frame(23, 4);
    good_frame(82, 15);

    // gap too short: error on data rise, then drain the pulse
    drive(1'b1, 10);
    drive(1'b0, 2);
    drive(1'b1, 1);
    expect_ev(1'b1, 0);
    drive(1'b1, 9);
    drive(1'b0, 4);

    // gap overflow: error on the 83rd low edge
    drive(1'b1, 10);
    drive(1'b0, 83);
    expect_ev(1'b1, 0);
    drive(1'b0, 4);
    check("busy_after_overflow", 32'(busy), 32'd0);

    // data width limits
    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 8);
    drive(1'b0, 1);
    expect_ev(1'b0, 3);
    drive(1'b0, 4);

    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 7);
    drive(1'b0, 1);
    expect_ev(1'b1, 0);
    drive(1'b0, 4);

    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 13);
    expect_ev(1'b1, 0);
    drive(1'b1, 3);
    check("busy_in_drain", 32'(busy), 32'd1);
    drive(1'b0, 3);
    check("busy_after_drain", 32'(busy), 32'd0);
    good_frame(45, 8);

    // short sync: silently dropped
    drive(1'b1, 7);
    drive(1'b0, 5);
    check("busy_after_short_sync", 32'(busy), 32'd0);

    // reset in the middle of a data pulse
    drive(1'b1, 10);
    drive(1'b0, 20);
    drive(1'b1, 5);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_data", 32'(data), 32'd0);
    check("midreset_valid", 32'(data_valid), 32'd0);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse_in = 1'b0;
    drive(1'b0, 3);
    good_frame(45, 8);

    drive(1'b0, 6);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
